// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked WIDTH-bit ALU holding one result until the consumer takes it.
// Define ALU_PIPE_MUL_EN to enable the multi-cycle shift-add unsigned multiplier on op 4'b1000.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_c,
  output logic             zero,
  output logic             overflow,
  output logic             out_err
);

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_DONE, S_BUSY} state_t;
  localparam int CW = $clog2(WIDTH);
`else
  typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q, z_q, v_q, err_q;
  logic [WIDTH-1:0] s_d;
  logic             c_d, v_d, err_d;
  logic [WIDTH:0]   add_w, sub_w;
  logic             accept;

  // rst_n gates in_ready so no beat looks accepted while reset is held
  assign in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_s     = s_q;
  assign out_c     = c_q;
  assign zero      = z_q;
  assign overflow  = v_q;
  assign out_err   = err_q;

  always_comb begin
    add_w = {1'b0, in_x} + {1'b0, in_y} + {{WIDTH{1'b0}}, in_c};
    sub_w = {1'b0, in_x} + {1'b0, ~in_y} + {{WIDTH{1'b0}}, 1'b1};
    s_d   = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    err_d = 1'b0;
    case (op)
      4'b0000: begin
        s_d = add_w[WIDTH-1:0];
        c_d = add_w[WIDTH];
        v_d = (in_x[WIDTH-1] == in_y[WIDTH-1]) & (add_w[WIDTH-1] != in_x[WIDTH-1]);
      end
      4'b0001: begin
        s_d = sub_w[WIDTH-1:0];
        c_d = sub_w[WIDTH];
        v_d = (in_x[WIDTH-1] != in_y[WIDTH-1]) & (sub_w[WIDTH-1] != in_x[WIDTH-1]);
      end
      4'b0010: s_d = ~in_x;
      4'b0011: s_d = in_x & in_y;
      4'b0100: s_d = in_x | in_y;
      4'b0101: s_d = in_x ^ in_y;
      4'b0110: s_d = {{(WIDTH-1){1'b0}}, ($signed(in_x) < $signed(in_y))};
      4'b0111: s_d = {{(WIDTH-1){1'b0}}, (in_x == in_y)};
      default: err_d = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0]   mcand_q, hi_q, lo_q, hi_out_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_nxt;
  logic               is_mul;

  assign is_mul = (op == 4'b1000);
  assign out_hi = hi_out_q;

  // {hi,lo} starts as {0,Y}; each step adds X on lo[0] and shifts right one bit
  always_comb begin
    step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_nxt = {step_sum, lo_q[WIDTH-1:1]};
  end
`else
  assign out_hi = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_out_q <= '0;
      cnt_q    <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_PIPE_MUL_EN
      if (is_mul) begin
        state_q <= S_BUSY;
        mcand_q <= in_x;
        hi_q    <= '0;
        lo_q    <= in_y;
        cnt_q   <= '0;
      end else
`endif
      begin
        state_q <= S_DONE;
        s_q     <= s_d;
        c_q     <= c_d;
        v_q     <= v_d;
        err_q   <= err_d;
        z_q     <= (s_d == '0);
`ifdef ALU_PIPE_MUL_EN
        hi_out_q <= '0;
`endif
      end
    end else if ((state_q == S_DONE) && out_ready) begin
      state_q <= S_IDLE;
`ifdef ALU_PIPE_MUL_EN
    end else if (state_q == S_BUSY) begin
      hi_q  <= step_nxt[2*WIDTH-1:WIDTH];
      lo_q  <= step_nxt[WIDTH-1:0];
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH-1)) begin
        state_q  <= S_DONE;
        s_q      <= step_nxt[WIDTH-1:0];
        hi_out_q <= step_nxt[2*WIDTH-1:WIDTH];
        c_q      <= |step_nxt[2*WIDTH-1:WIDTH];
        v_q      <= |step_nxt[2*WIDTH-1:WIDTH];
        err_q    <= 1'b0;
        z_q      <= (step_nxt[WIDTH-1:0] == '0);
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results on acceptance, monitor compares on out_valid.
module tb_alu_pipe;
  localparam int W    = 4;
  localparam int FULL = 1 << W;
  localparam int HALF = FULL / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic         in_c = 1'b0;
  logic [W-1:0] in_x = '0, in_y = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_s, out_hi;
  logic         out_c, zero, overflow, out_err;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .in_c(in_c),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_hi(out_hi), .out_c(out_c), .zero(zero), .overflow(overflow), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s, hi, c, z, v, err, lat, exp_cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held by directed code

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int o, input int x, input int y, input int c);
    exp_t e;
    int sx, sy, t;
    sx = (x >= HALF) ? x - FULL : x;
    sy = (y >= HALF) ? y - FULL : y;
    e.s = 0; e.hi = 0; e.c = 0; e.v = 0; e.err = 0; e.lat = 1; e.exp_cyc = 0;
    case (o)
      0: begin
        t = x + y + c; e.s = t % FULL; e.c = int'(t >= FULL);
        e.v = int'((sx + sy + c > HALF - 1) || (sx + sy + c < -HALF));
      end
      1: begin
        t = x + (FULL - 1 - y) + 1; e.s = t % FULL; e.c = int'(t >= FULL);
        e.v = int'((sx - sy > HALF - 1) || (sx - sy < -HALF));
      end
      2: e.s = FULL - 1 - x;
      3: e.s = x & y;
      4: e.s = x | y;
      5: e.s = x ^ y;
      6: e.s = int'(sx < sy);
      7: e.s = int'(x == y);
`ifdef ALU_PIPE_MUL_EN
      8: begin
        t = x * y; e.s = t % FULL; e.hi = t / FULL;
        e.c = int'(e.hi != 0); e.v = e.c; e.lat = W;
      end
`endif
      default: e.err = 1;
    endcase
    e.z = int'(e.s == 0);
    return e;
  endfunction

  // Ready generator
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares the head entry every cycle it is shown, pops on handshake
  initial begin
    bit   seen;
    exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = q[0];
          chk("out_s", int'(out_s), e.s);
          chk("out_hi", int'(out_hi), e.hi);
          chk("out_c", int'(out_c), e.c);
          chk("zero", int'(zero), e.z);
          chk("overflow", int'(overflow), e.v);
          chk("out_err", int'(out_err), e.err);
          if (!seen) begin
            chk("latency_cycle", cyc, e.exp_cyc);
            seen = 1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat
  task automatic send(input int o, input int x, input int y, input int c);
    exp_t e;
    int   n;
    n = 0;
    op = 4'(o); in_x = W'(x); in_y = W'(y); in_c = 1'(c); in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = model(o, x, y, c);
        e.exp_cyc = cyc + e.lat;
        q.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int o;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_s", int'(out_s), 0);
    chk("rst_flags", int'({out_c, zero, overflow, out_err}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Directed vectors, back-to-back with out_ready=1
    send(0, 7, 1, 0);
    send(0, 3, 13, 0);
    send(1, 8, 1, 0);
    send(6, 15, 1, 0);
    send(7, 10, 10, 0);
    send(11, 3, 4, 1);
    send(1, 8, 1, 1);
    send(0, 15, 0, 1);
    send(2, 5, 0, 0);
    drain();

    // Backpressure: result held, in_ready low while consumer stalls
    rdy_mode = 2;
    send(1, 5, 5, 0);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    rdy_mode = 0;
    drain();

`ifdef ALU_PIPE_MUL_EN
    send(8, 15, 15, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mul_busy_in_ready", int'(in_ready), 0);
    end
    drain();
`endif

    // Reset in the middle of a multiply (a reserved op when MUL is disabled)
    send(8, 15, 15, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_s", int'(out_s), 0);
    chk("midrst_out_hi", int'(out_hi), 0);
    chk("midrst_flags", int'({out_c, zero, overflow, out_err}), 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 1, 1, 0);
    drain();

    // Randomized traffic with random backpressure and idle gaps
    rdy_mode = 1;
    repeat (300) begin
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
      send(o, int'($urandom_range(0, FULL - 1)), int'($urandom_range(0, FULL - 1)),
           int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rdy_mode = 0;
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
